// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and lane helpers for the data-memory RMW
//                controller (access size, FSM states, lane extract/merge).
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B   = 2'd0,
      SZ_H   = 2'd1,
      SZ_W   = 2'd2,
      SZ_BAD = 2'd3
   } size_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LD_WAIT = 3'd1,
      LD_CAP  = 3'd2,
      ST_WR   = 3'd3,
      RMW_RD  = 3'd4,
      RMW_MRG = 3'd5
   } state_e;

   // Pick the addressed byte/half out of a word and sign- or zero-extend it.
   // Halves are selected by lane[1]; words pass straight through.
   function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input size_e       size,
                                                input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_B:    r = {{24{b[7] & ~uns}}, b};
         SZ_H:    r = {{16{h[15] & ~uns}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace the addressed byte/half of a word with right-aligned store data.
   function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input size_e       size,
                                              input logic [15:0] wdata);
      logic [31:0] r;
      r = word;
      case (size)
         SZ_B: r[{lane, 3'b000} +: 8] = wdata[7:0];
         SZ_H: begin
            if (lane[1]) r[31:16] = wdata;
            else         r[15:0]  = wdata;
         end
         default: r = word;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_fmt
//  Description : Combinational lane formatter: load extract/extend and
//                sub-word store merge on the SRAM read word.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_fmt
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  size_e       size,
   input  logic        uns,
   input  logic [15:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] merge_val
);

   // Both results are cheap; the controller picks whichever its state needs.
   always_comb begin
      load_val  = lane_extract(word, lane, size, uns);
      merge_val = lane_merge(word, lane, size, wdata);
   end

endmodule
`default_nettype wire

// File: rtl/ram_16384x32.sv
`default_nettype none
// ============================================================================
//  Module      : ram_16384x32
//  Description : Behavioural single-port synchronous SRAM, 1-cycle read
//                latency, no byte mask. Q is poisoned after a write cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_16384x32 (
   input  logic        CLK,
   input  logic [13:0] ADR,
   input  logic [31:0] D,
   input  logic        WE,
   output logic [31:0] Q
);

   localparam logic [31:0] C_POISON = 32'hBAD0_BAD0;

   logic [31:0] mem [0:16383];

   // Write or read on every edge; Q is garbage in the cycle after a write.
   always_ff @(posedge CLK) begin
      if (WE) begin
         mem[ADR] <= D;
         Q        <= C_POISON;
      end else begin
         Q        <= mem[ADR];
      end
   end

endmodule
`default_nettype wire

// File: rtl/dmem_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_rmw_ctrl
//  Description : RV32I load/store controller for a single-port 32-bit SRAM,
//                with read-modify-write for byte/half stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_rmw_ctrl
   import dmem_pkg::*;
#(
   parameter int          ADDR_W    = 14,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] ADR,
   output logic [31:0]       D,
   output logic              WE,
   input  logic [31:0]       Q
);

   localparam int SPAN_LSB = ADDR_W + 2;

   state_e            r_state;
   state_e            w_state_nx;
   logic [ADDR_W-1:0] w_adr_nx;
   logic [31:0]       w_d_nx;
   logic              w_we_nx;
   logic              w_rsp_valid_nx;
   logic [31:0]       w_rsp_rdata_nx;
   logic              w_rsp_err_nx;

   logic [1:0]        r_lane;
   size_e             r_size;
   logic              r_uns;
   logic [15:0]       r_wdata;

   logic [31:0]       w_offset;
   size_e             w_req_sz;
   logic              w_bad;
   logic              w_accept;
   logic [31:0]       w_load_val;
   logic [31:0]       w_merge_val;

   // Offset wraps for addresses below the base, so one high-bit test covers both ends.
   assign w_offset  = req_addr - BASE_ADDR;
   assign w_req_sz  = size_e'(req_size);
   assign w_bad     = (w_req_sz == SZ_BAD)
                    || (w_req_sz == SZ_H && w_offset[0])
                    || (w_req_sz == SZ_W && w_offset[1:0] != 2'b00)
                    || (w_offset[31:SPAN_LSB] != '0);
   assign req_ready = (r_state == IDLE);
   assign w_accept  = req_valid && req_ready;

   dmem_lane_fmt u_fmt (
      .word      (Q),
      .lane      (r_lane),
      .size      (r_size),
      .uns       (r_uns),
      .wdata     (r_wdata),
      .load_val  (w_load_val),
      .merge_val (w_merge_val)
   );

   // Latch the request fields needed after the accept cycle.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_lane  <= 2'd0;
         r_size  <= SZ_B;
         r_uns   <= 1'b0;
         r_wdata <= 16'd0;
      end else if (w_accept) begin
         r_lane  <= w_offset[1:0];
         r_size  <= w_req_sz;
         r_uns   <= req_unsigned;
         r_wdata <= req_wdata[15:0];
      end
   end

   // State and SRAM/response registers; reset abandons any in-flight access.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= IDLE;
         ADR       <= '0;
         D         <= 32'd0;
         WE        <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         ADR       <= w_adr_nx;
         D         <= w_d_nx;
         WE        <= w_we_nx;
         rsp_valid <= w_rsp_valid_nx;
         rsp_rdata <= w_rsp_rdata_nx;
         rsp_err   <= w_rsp_err_nx;
      end
   end

   // Next-state and next-output logic; response fields default to zero so
   // rsp_* are only non-zero in the pulse cycle.
   always_comb begin
      w_state_nx     = r_state;
      w_adr_nx       = ADR;
      w_d_nx         = D;
      w_we_nx        = 1'b0;
      w_rsp_valid_nx = 1'b0;
      w_rsp_rdata_nx = 32'd0;
      w_rsp_err_nx   = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               if (w_bad) begin
                  w_rsp_valid_nx = 1'b1;
                  w_rsp_err_nx   = 1'b1;
               end else begin
                  w_adr_nx = w_offset[SPAN_LSB-1:2];
                  if (!req_we) begin
                     w_state_nx = LD_WAIT;
                  end else if (w_req_sz == SZ_W) begin
                     w_state_nx = ST_WR;
                     w_d_nx     = req_wdata;
                     w_we_nx    = 1'b1;
                  end else begin
                     w_state_nx = RMW_RD;
                  end
               end
            end
         end
         LD_WAIT: w_state_nx = LD_CAP;
         LD_CAP: begin
            w_rsp_rdata_nx = w_load_val;
            w_rsp_valid_nx = 1'b1;
            w_state_nx     = IDLE;
         end
         RMW_RD: w_state_nx = RMW_MRG;
         RMW_MRG: begin
            w_d_nx     = w_merge_val;
            w_we_nx    = 1'b1;
            w_state_nx = ST_WR;
         end
         ST_WR: begin
            w_rsp_valid_nx = 1'b1;
            w_state_nx     = IDLE;
         end
         default: w_state_nx = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_rmw_ctrl
//  Description : Self-checking bench for dmem_rmw_ctrl with SRAM model and
//                an arithmetic reference model of load/store behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_rmw_ctrl;

   localparam int          ADDR_W = 14;
   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam logic [31:0] SPAN   = 32'h4 << ADDR_W;

   logic              CLK = 1'b0;
   logic              RST_N = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [31:0]       req_addr = 32'd0;
   logic [1:0]        req_size = 2'd0;
   logic              req_unsigned = 1'b0;
   logic [31:0]       req_wdata = 32'd0;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] ADR;
   logic [31:0]       D;
   logic              WE;
   logic [31:0]       Q;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int acc_q[$];
   logic [31:0] model_mem [0:31];

   dmem_rmw_ctrl #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) u_dut (
      .CLK(CLK), .RST_N(RST_N),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ADR(ADR), .D(D), .WE(WE), .Q(Q)
   );

   ram_16384x32 u_ram (.CLK(CLK), .ADR(ADR), .D(D), .WE(WE), .Q(Q));

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (RST_N && req_valid && req_ready) acc_q.push_back(cyc);
      cyc <= cyc + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                          input int sz, input logic u);
      logic [31:0] v;
      if (sz == 0) begin
         v = (w >> (8 * (a % 4))) & 32'hFF;
         if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 1) begin
         v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
         if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] a,
                                           input int sz, input logic [31:0] d);
      logic [31:0] mask;
      int sh;
      if (sz == 2) return d;
      sh   = (sz == 0) ? 8 * int'(a % 4) : 16 * int'((a / 2) % 2);
      mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << sh;
      return (w & ~mask) | ((d << sh) & mask);
   endfunction

   function automatic logic m_err(input logic [31:0] a, input int sz);
      return (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0)
             || ((a - BASE) >= SPAN);
   endfunction

   function automatic int m_lat(input logic we, input logic [31:0] a, input int sz);
      if (m_err(a, sz)) return 1;
      if (!we)          return 3;
      if (sz == 2)      return 2;
      return 4;
   endfunction

   // ---------------- transaction driver (no checking) ----------------
   task automatic run_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int we_cnt, output int we_first);
      @(negedge CLK);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wdata;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      lat = -1; rd = 32'd0; er = 1'b0; we_cnt = 0; we_first = -1;
      for (int i = 1; i <= 10; i++) begin
         if (WE) begin
            we_cnt++;
            if (we_first < 0) we_first = i;
         end
         if (rsp_valid) begin
            lat = i; rd = rsp_rdata; er = rsp_err;
            break;
         end
         @(posedge CLK); #1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int seen_rsp = 0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_size = 2'd2; req_wdata = 32'h1234_5678;
      repeat (3) begin
         @(posedge CLK); #1;
         if (rsp_valid || WE) seen_rsp++;
      end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
      checks++; if (WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", WE); end
      checks++; if (ADR !== '0) begin errors++; $display("FAIL reset_adr: got %h expected 0", ADR); end
      checks++; if (D !== 32'd0) begin errors++; $display("FAIL reset_d: got %h expected 0", D); end
      checks++; if ({rsp_valid, rsp_err} !== 2'b00 || rsp_rdata !== 32'd0) begin
         errors++; $display("FAIL reset_rsp: got v=%b e=%b d=%h expected all 0", rsp_valid, rsp_err, rsp_rdata);
      end
      @(negedge CLK); req_valid = 1'b0; RST_N = 1'b1;
      repeat (4) begin
         @(posedge CLK); #1;
         if (rsp_valid || WE) seen_rsp++;
      end
      checks++; if (seen_rsp != 0) begin errors++; $display("FAIL reset_ignored: got %0d activity cycles expected 0", seen_rsp); end
   endtask

   task automatic test_word_access();
      int lat, wc, wf; logic [31:0] rd; logic er;
      run_req(1'b1, 32'h14, 2'd2, 1'b0, 32'h8899_AABB, lat, rd, er, wc, wf);
      checks++; if (lat != 2 || er !== 1'b0 || wc != 1 || wf != 1) begin
         errors++; $display("FAIL sw_timing: got lat=%0d err=%b we_cnt=%0d we_at=%0d expected 2/0/1/1", lat, er, wc, wf);
      end
      checks++; if (u_ram.mem[5] !== 32'h8899_AABB) begin
         errors++; $display("FAIL sw_mem: got %h expected 8899aabb", u_ram.mem[5]);
      end
      run_req(1'b0, 32'h14, 2'd2, 1'b0, 32'd0, lat, rd, er, wc, wf);
      checks++; if (lat != 3 || rd !== 32'h8899_AABB || er !== 1'b0 || wc != 0) begin
         errors++; $display("FAIL lw: got lat=%0d data=%h err=%b we_cnt=%0d expected 3/8899aabb/0/0", lat, rd, er, wc);
      end
   endtask

   task automatic test_subword_loads();
      logic [31:0] ad [4] = '{32'h15, 32'h15, 32'h16, 32'h16};
      logic [1:0]  sz [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
      logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] ex [4] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899, 32'h0000_8899};
      int lat, wc, wf; logic [31:0] rd; logic er;
      for (int i = 0; i < 4; i++) begin
         run_req(1'b0, ad[i], sz[i], un[i], 32'hFFFF_FFFF, lat, rd, er, wc, wf);
         checks++; if (lat != 3 || rd !== ex[i] || er !== 1'b0) begin
            errors++; $display("FAIL subload_%0d: got lat=%0d data=%h err=%b expected 3/%h/0", i, lat, rd, er, ex[i]);
         end
      end
   endtask

   task automatic test_subword_stores();
      int lat, wc, wf; logic [31:0] rd; logic er;
      run_req(1'b1, 32'h16, 2'd0, 1'b0, 32'hFFFF_FF12, lat, rd, er, wc, wf);
      checks++; if (lat != 4 || wc != 1 || wf != 3 || er !== 1'b0 || rd !== 32'd0) begin
         errors++; $display("FAIL sb_timing: got lat=%0d we_cnt=%0d we_at=%0d err=%b data=%h expected 4/1/3/0/0", lat, wc, wf, er, rd);
      end
      checks++; if (u_ram.mem[5] !== 32'h8812_AABB) begin
         errors++; $display("FAIL sb_mem: got %h expected 8812aabb", u_ram.mem[5]);
      end
      run_req(1'b1, 32'h14, 2'd1, 1'b0, 32'hABCD_3344, lat, rd, er, wc, wf);
      checks++; if (lat != 4 || wc != 1 || wf != 3) begin
         errors++; $display("FAIL sh_timing: got lat=%0d we_cnt=%0d we_at=%0d expected 4/1/3", lat, wc, wf);
      end
      checks++; if (u_ram.mem[5] !== 32'h8812_3344) begin
         errors++; $display("FAIL sh_mem: got %h expected 88123344", u_ram.mem[5]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd_q[$];
      acc_q.delete();
      @(negedge CLK);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 2'd2; req_wdata = 32'hDEAD_BEEF;
      @(posedge CLK); #1;
      req_we = 1'b0; req_wdata = 32'd0;
      for (int i = 0; i < 20 && rd_q.size() < 3; i++) begin
         if (acc_q.size() >= 3) req_valid = 1'b0;
         if (rsp_valid) rd_q.push_back(rsp_rdata);
         @(posedge CLK); #1;
      end
      req_valid = 1'b0;
      checks++; if (acc_q.size() < 3 || rd_q.size() < 3) begin
         errors++; $display("FAIL b2b_count: got accepts=%0d responses=%0d expected 3/3", acc_q.size(), rd_q.size());
      end else begin
         checks++; if (acc_q[1] - acc_q[0] != 2 || acc_q[2] - acc_q[1] != 3) begin
            errors++; $display("FAIL b2b_spacing: got %0d,%0d expected 2,3", acc_q[1] - acc_q[0], acc_q[2] - acc_q[1]);
         end
         checks++; if (rd_q[0] !== 32'd0 || rd_q[1] !== 32'hDEAD_BEEF || rd_q[2] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL b2b_data: got %h %h %h expected 0 deadbeef deadbeef", rd_q[0], rd_q[1], rd_q[2]);
         end
      end
      repeat (4) @(posedge CLK);
   endtask

   task automatic test_errors();
      logic [31:0] ad [5] = '{32'h13, 32'h11, 32'h14, BASE + 32'h1_0000, 32'h22};
      logic [1:0]  sz [5] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2};
      logic        we [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int lat, wc, wf; logic [31:0] rd; logic er;
      for (int i = 0; i < 5; i++) begin
         run_req(we[i], ad[i], sz[i], 1'b0, 32'h5555_AAAA, lat, rd, er, wc, wf);
         checks++; if (lat != 1 || er !== 1'b1 || rd !== 32'd0 || wc != 0) begin
            errors++; $display("FAIL err_%0d: got lat=%0d err=%b data=%h we_cnt=%0d expected 1/1/0/0", i, lat, er, rd, wc);
         end
      end
      checks++; if (u_ram.mem[8] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL err_mem: got %h expected deadbeef", u_ram.mem[8]);
      end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      int lat, wc, wf; logic [31:0] rd; logic er;
      // Sub-word store aborted in RMW_MRG.
      @(negedge CLK);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h14; req_size = 2'd1; req_wdata = 32'h5566;
      @(posedge CLK); #1; req_valid = 1'b0;
      @(posedge CLK); #1;
      RST_N = 1'b0; #1;
      checks++; if (WE !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL rstmid_rmw: got we=%b rsp=%b expected 0/0", WE, rsp_valid);
      end
      // Word store aborted while WE is high.
      @(negedge CLK); RST_N = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 2'd2; req_wdata = 32'h1111_2222;
      @(posedge CLK); #1; req_valid = 1'b0;
      checks++; if (WE !== 1'b1) begin errors++; $display("FAIL rstmid_we_on: got %b expected 1", WE); end
      RST_N = 1'b0; #1;
      checks++; if (WE !== 1'b0) begin errors++; $display("FAIL rstmid_we_drop: got %b expected 0", WE); end
      @(posedge CLK); #1;
      @(negedge CLK); RST_N = 1'b1;
      repeat (5) begin
         @(posedge CLK); #1;
         if (rsp_valid || WE) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", bad); end
      checks++; if (u_ram.mem[5] !== 32'h8812_3344 || u_ram.mem[8] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL rstmid_mem: got %h %h expected 88123344 deadbeef", u_ram.mem[5], u_ram.mem[8]);
      end
      run_req(1'b0, 32'h14, 2'd2, 1'b0, 32'd0, lat, rd, er, wc, wf);
      checks++; if (lat != 3 || rd !== 32'h8812_3344 || er !== 1'b0) begin
         errors++; $display("FAIL rstmid_next: got lat=%0d data=%h err=%b expected 3/88123344/0", lat, rd, er);
      end
   endtask

   task automatic test_random();
      int lat, wc, wf, sz, k; logic [31:0] rd, a, wd, exp_rd; logic er, we, un, exp_er;
      for (int w = 0; w < 32; w++) begin
         wd = $urandom;
         run_req(1'b1, 32'(w * 4), 2'd2, 1'b0, wd, lat, rd, er, wc, wf);
         model_mem[w] = wd;
      end
      for (int n = 0; n < 80; n++) begin
         k  = int'($urandom_range(0, 9));
         sz = (k == 1) ? 3 : int'($urandom_range(0, 2));
         a  = (k == 0) ? ((n % 2 == 0) ? BASE + SPAN + 32'($urandom_range(0, 255)) : 32'hFFFF_FFFC)
                       : 32'($urandom_range(0, 127));
         we = 1'($urandom_range(0, 1));
         un = 1'($urandom_range(0, 1));
         wd = $urandom;
         exp_er = m_err(a, sz);
         exp_rd = (exp_er || we) ? 32'd0 : m_load(model_mem[a[6:2]], a, sz, un);
         run_req(we, a, 2'(sz), un, wd, lat, rd, er, wc, wf);
         checks++; if (lat != m_lat(we, a, sz) || er !== exp_er || rd !== exp_rd
                       || wc != ((we && !exp_er) ? 1 : 0)) begin
            errors++;
            $display("FAIL rand_%0d we=%b a=%h sz=%0d: got lat=%0d err=%b data=%h we_cnt=%0d expected %0d/%b/%h/%0d",
                     n, we, a, sz, lat, er, rd, wc, m_lat(we, a, sz), exp_er, exp_rd, (we && !exp_er) ? 1 : 0);
         end
         if (we && !exp_er) begin
            model_mem[a[6:2]] = m_store(model_mem[a[6:2]], a, sz, wd);
            checks++; if (u_ram.mem[a[6:2]] !== model_mem[a[6:2]]) begin
               errors++; $display("FAIL rand_mem_%0d: got %h expected %h", n, u_ram.mem[a[6:2]], model_mem[a[6:2]]);
            end
         end
         @(posedge CLK); #1;
         checks++; if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rand_pulse_%0d: got rsp_valid=%b expected 0", n, rsp_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_word_access();
      test_subword_loads();
      test_subword_stores();
      test_back_to_back();
      test_errors();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
